// File: rtl/mext_issue_stage.sv
// Issue/retire stage in front of the combinational M-extension unit (cop0): holds operands for a
// fixed multicycle latency, then captures and presents the result. Optional macro: RISCV_DIV_SPECIAL_EN.
module mext_issue_stage #(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned DIV_LAT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [31:0] issue_a,
   input  logic [31:0] issue_b,
   input  logic [2:0]  issue_funct3,
   input  logic [4:0]  issue_rd,
   input  logic        flush,
   output logic [31:0] cop_a,
   output logic [31:0] cop_b,
   output logic [2:0]  cop_funct3,
   input  logic [31:0] cop_ans,
   output logic        stall,
   output logic        busy,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd
);

   if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
      $error("mext_issue_stage: MUL_LAT=%0d outside 1..15", MUL_LAT);
   end
   if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
      $error("mext_issue_stage: DIV_LAT=%0d outside 1..15", DIV_LAT);
   end

   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
   localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] cop_a_q, cop_b_q;
   logic [2:0]  cop_funct3_q;
   logic [4:0]  rd_q;
   logic        wb_valid_q;
   logic [31:0] wb_data_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] result_d;

`ifdef RISCV_DIV_SPECIAL_EN
   // Divide-by-zero and signed overflow follow the RISC-V M rules regardless of what cop0 returns.
   always_comb begin
      result_d = cop_ans;
      if (cop_funct3_q[2]) begin
         if (cop_b_q == '0) begin
            result_d = cop_funct3_q[1] ? cop_a_q : '1;
         end else if (!cop_funct3_q[0] && cop_a_q == 32'h8000_0000 && cop_b_q == '1) begin
            result_d = cop_funct3_q[1] ? '0 : 32'h8000_0000;
         end
      end
   end
`else
   assign result_d = cop_ans;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         cop_a_q      <= '0;
         cop_b_q      <= '0;
         cop_funct3_q <= '0;
         rd_q         <= '0;
         wb_valid_q   <= 1'b0;
         wb_data_q    <= '0;
         wb_rd_q      <= '0;
      end else if (flush) begin
         state_q    <= S_IDLE;
         wb_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (issue_valid) begin
                  cop_a_q      <= issue_a;
                  cop_b_q      <= issue_b;
                  cop_funct3_q <= issue_funct3;
                  rd_q         <= issue_rd;
                  cnt_q        <= issue_funct3[2] ? DIV_CNT : MUL_CNT;
                  state_q      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  wb_data_q  <= result_d;
                  wb_rd_q    <= rd_q;
                  wb_valid_q <= 1'b1;
                  state_q    <= S_DONE;
               end
            end
            S_DONE: begin
               if (wb_ready) begin
                  wb_valid_q <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign issue_ready = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign stall       = busy;
   assign cop_a       = cop_a_q;
   assign cop_b       = cop_b_q;
   assign cop_funct3  = cop_funct3_q;
   assign wb_valid    = wb_valid_q;
   assign wb_data     = wb_data_q;
   assign wb_rd       = wb_rd_q;

endmodule
